// File: rtl/alu_result_buffer_pkg.sv
// Shared widths and helpers for the ALU result write-back buffer.
package alu_result_buffer_pkg;

    localparam int unsigned WB_DATA_W     = 16;
    localparam int unsigned WB_REG_ADDR_W = 2;
    localparam int unsigned WB_DEPTH      = 2;

    typedef logic [1:0] wb_count_t;

    function automatic logic wb_is_full(input wb_count_t c);
        return c == 2'(WB_DEPTH);
    endfunction

endpackage

// File: rtl/alu_result_buffer_sync_fifo2.sv
// Two-entry synchronous FIFO with registered head, count and full/empty.
module sync_fifo2
    import alu_result_buffer_pkg::*;
#(
    parameter int unsigned W = WB_DATA_W + WB_REG_ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output wb_count_t    count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    wb_count_t    cnt_q, cnt_d;
    logic [W-1:0] head_q, head_d;
    logic         full_q, empty_q;

    // The head is a register so it holds its last value once the FIFO drains.
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wdata;
                wr_d        = ~wr_q;
            end
            if (pop) begin
                rd_d = ~rd_q;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
            if (cnt_d != '0) begin
                head_d = mem_d[rd_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            head_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            full_q  <= wb_is_full(cnt_d);
            empty_q <= (cnt_d == '0);
        end
    end

    assign rdata = head_q;
    assign count = cnt_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/alu_result_buffer.sv
// Captures ALU results, owns the carry flag fed back to Cin, and queues
// register write-backs in a 2-entry FIFO drained by valid/ready.
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned REG_ADDR_W = WB_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic                  in_cout,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_wr_reg,
    input  logic                  in_wr_flag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  carry_flag,
    output logic [1:0]            count
);

    localparam int unsigned EW = DATA_W + REG_ADDR_W;

    logic          accept, push, pop;
    logic          full, empty;
    logic [EW-1:0] head;
    logic          carry_q, carry_d;

    // Flush discards the incoming op entirely, including its flag update.
    assign accept = in_valid & in_ready & ~flush;
    assign push   = accept & in_wr_reg;
    assign pop    = out_valid & out_ready & ~flush;

    always_comb begin
        carry_d = carry_q;
        if (accept && in_wr_flag) begin
            carry_d = in_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    sync_fifo2 #(
        .W(EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata ({in_result, in_dest}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign in_ready              = ~full;
    assign out_valid             = ~empty;
    assign {out_data, out_dest}  = head;
    assign carry_flag            = carry_q;

endmodule
